// File: rtl/issue_group_splitter.sv
// issue_group_splitter
//   Holds one decode bundle and breaks it into in-order issue groups. Each
//   group obeys a per-cycle memory-op limit, a branch limit and, optionally,
//   a "branch ends the group" rule. The oldest pending slot always issues,
//   so every bundle drains in at most NUM_WIDTH groups.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   bundle handshake
//   in_slot_valid         per-slot instruction present (slot 0 oldest)
//   in_branch             per-slot branch flag
//   in_mem_read/_write    per-slot memory flags (either marks a memory op)
//   flush                 drop the held bundle, block acceptance this cycle
//   out_valid / out_ready issue group handshake
//   issue_mask            slots issuing in the current group
//   out_last              current group empties the held bundle
module issue_group_splitter #(
  parameter int NUM_WIDTH     = 3,
  parameter int MAX_MEM       = 1,
  parameter int MAX_BR        = 1,
  parameter int BR_ENDS_GROUP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_WIDTH-1:0] in_slot_valid,
  input  logic [NUM_WIDTH-1:0] in_branch,
  input  logic [NUM_WIDTH-1:0] in_mem_read,
  input  logic [NUM_WIDTH-1:0] in_mem_write,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_WIDTH-1:0] issue_mask,
  output logic                 out_last
);

  if (MAX_MEM < 1 || MAX_MEM > NUM_WIDTH) begin : g_bad_mem
    $error("issue_group_splitter: MAX_MEM out of range");
  end
  if (MAX_BR < 1 || MAX_BR > NUM_WIDTH) begin : g_bad_br
    $error("issue_group_splitter: MAX_BR out of range");
  end

  logic [NUM_WIDTH-1:0] pending_q, pending_d;
  logic [NUM_WIDTH-1:0] br_q, br_d;
  logic [NUM_WIDTH-1:0] mem_q, mem_d;
  logic [NUM_WIDTH-1:0] mask;
  logic                 accept;
  logic                 issue;

  // HOLD is simply "anything pending"; no separate state register.
  assign out_valid = |pending_q;

  // Group selection. Non-pending slots are holes and do not stop the scan;
  // the first pending slot that violates a limit stops it for all younger.
  always_comb begin
    int  mcnt;
    int  bcnt;
    logic blocked;
    logic br_seen;
    mask    = '0;
    mcnt    = 0;
    bcnt    = 0;
    blocked = 1'b0;
    br_seen = 1'b0;
    for (int i = 0; i < NUM_WIDTH; i++) begin
      if (pending_q[i] && !blocked) begin
        if (mask == '0 ||
            ((mcnt + int'(mem_q[i])) <= MAX_MEM &&
             (bcnt + int'(br_q[i])) <= MAX_BR &&
             (BR_ENDS_GROUP == 0 || !br_seen))) begin
          mask[i] = 1'b1;
          mcnt    = mcnt + int'(mem_q[i]);
          bcnt    = bcnt + int'(br_q[i]);
          br_seen = br_seen | br_q[i];
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  assign issue_mask = mask;
  assign out_last   = out_valid && (mask == pending_q);
  assign in_ready   = !reset && !flush && (!out_valid || (out_ready && out_last));
  assign accept     = in_valid && in_ready;
  assign issue      = out_valid && out_ready;

  // Flags are masked by slot valid at capture so stale flags can never
  // leak into the counts.
  always_comb begin
    pending_d = pending_q;
    br_d      = br_q;
    mem_d     = mem_q;
    if (flush) begin
      pending_d = '0;
    end else if (accept) begin
      // Accepting implies the held bundle (if any) is finishing this edge.
      pending_d = in_slot_valid;
      br_d      = in_branch & in_slot_valid;
      mem_d     = (in_mem_read | in_mem_write) & in_slot_valid;
    end else if (issue) begin
      pending_d = pending_q & ~mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      br_q      <= '0;
      mem_q     <= '0;
    end else begin
      pending_q <= pending_d;
      br_q      <= br_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_issue_group_splitter.sv
module tb_issue_group_splitter;
  localparam int W = 3;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready, in_ready2;
  logic [W-1:0] in_slot_valid, in_branch, in_mem_read, in_mem_write;
  logic         flush;
  logic         out_valid, out_valid2;
  logic         out_ready;
  logic [W-1:0] issue_mask, issue_mask2;
  logic         out_last, out_last2;

  int errs   = 0;
  int checks = 0;

  issue_group_splitter #(.NUM_WIDTH(W), .MAX_MEM(1), .MAX_BR(1), .BR_ENDS_GROUP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_slot_valid(in_slot_valid), .in_branch(in_branch), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .issue_mask(issue_mask), .out_last(out_last)
  );

  issue_group_splitter #(.NUM_WIDTH(W), .MAX_MEM(1), .MAX_BR(1), .BR_ENDS_GROUP(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_slot_valid(in_slot_valid), .in_branch(in_branch), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .issue_mask(issue_mask2), .out_last(out_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [W-1:0] v, input logic [W-1:0] br,
                       input logic [W-1:0] rd, input logic [W-1:0] wr);
    in_valid = 1'b1; in_slot_valid = v; in_branch = br;
    in_mem_read = rd; in_mem_write = wr;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_slot_valid = '0; in_branch = '0;
    in_mem_read = '0; in_mem_write = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    offer(3'b111, 3'b000, 3'b000, 3'b000);
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    tick(); #1;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (issue_mask !== 3'b000) begin errs++; $display("FAIL rst_mask got=%b exp=000", issue_mask); end
    checks++; if (out_last !== 1'b0) begin errs++; $display("FAIL rst_last got=%b exp=0", out_last); end
    reset = 1'b0; idle_in(); #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_plain();
    out_ready = 1'b1;
    offer(3'b111, 3'b000, 3'b000, 3'b000); #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL plain_accept got=%b exp=1", in_ready); end
    tick(); idle_in(); #1;
    checks++; if (issue_mask !== 3'b111) begin errs++; $display("FAIL plain_mask got=%b exp=111", issue_mask); end
    checks++; if (out_last !== 1'b1) begin errs++; $display("FAIL plain_last got=%b exp=1", out_last); end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL plain_ready got=%b exp=1", in_ready); end
    tick(); #1;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL plain_drained got=%b exp=0", out_valid); end
  endtask

  // Every slot is a memory op (reads on 0,1 and a write on 2): one per group.
  task automatic test_mem_split();
    logic [W-1:0] exp_m [3];
    exp_m[0] = 3'b001; exp_m[1] = 3'b010; exp_m[2] = 3'b100;
    out_ready = 1'b1;
    offer(3'b111, 3'b000, 3'b011, 3'b100); #1;
    tick(); idle_in(); #1;
    for (int g = 0; g < 3; g++) begin
      checks++; if (issue_mask !== exp_m[g]) begin errs++; $display("FAIL mem_mask%0d got=%b exp=%b", g, issue_mask, exp_m[g]); end
      checks++; if (out_last !== (g == 2)) begin errs++; $display("FAIL mem_last%0d got=%b exp=%b", g, out_last, (g == 2)); end
      checks++; if (in_ready !== (g == 2)) begin errs++; $display("FAIL mem_ready%0d got=%b exp=%b", g, in_ready, (g == 2)); end
      tick(); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mem_drained got=%b exp=0", out_valid); end
  endtask

  // A lone memory op does not stop younger non-memory slots.
  task automatic test_mem_join();
    out_ready = 1'b1;
    offer(3'b111, 3'b000, 3'b001, 3'b000); #1;
    tick(); idle_in(); #1;
    checks++; if (issue_mask !== 3'b111 || out_last !== 1'b1) begin errs++; $display("FAIL memjoin got=%b/%b exp=111/1", issue_mask, out_last); end
    tick();
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    offer(3'b111, 3'b001, 3'b000, 3'b000); #1;
    tick(); idle_in(); #1;
    checks++; if (issue_mask !== 3'b001 || out_last !== 1'b0) begin errs++; $display("FAIL br_g0 got=%b/%b exp=001/0", issue_mask, out_last); end
    checks++; if (issue_mask2 !== 3'b111 || out_last2 !== 1'b1) begin errs++; $display("FAIL br_noend got=%b/%b exp=111/1", issue_mask2, out_last2); end
    tick(); #1;
    checks++; if (issue_mask !== 3'b110 || out_last !== 1'b1) begin errs++; $display("FAIL br_g1 got=%b/%b exp=110/1", issue_mask, out_last); end
    checks++; if (out_valid2 !== 1'b0) begin errs++; $display("FAIL br_noend_done got=%b exp=0", out_valid2); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    offer(3'b111, 3'b000, 3'b000, 3'b110); #1;
    tick(); idle_in(); out_ready = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (issue_mask !== 3'b011 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        errs++; $display("FAIL stall%0d mask/last/ready got=%b/%b/%b exp=011/0/0", c, issue_mask, out_last, in_ready);
      end
      tick(); #1;
    end
    out_ready = 1'b1; #1;
    checks++; if (issue_mask !== 3'b011) begin errs++; $display("FAIL stall_release got=%b exp=011", issue_mask); end
    tick(); #1;
    checks++; if (issue_mask !== 3'b100 || out_last !== 1'b1) begin errs++; $display("FAIL stall_adv got=%b/%b exp=100/1", issue_mask, out_last); end
    tick();
  endtask

  // Read+write on one slot counts once; branch+mem counts against both;
  // flags on invalid slots are ignored.
  task automatic test_counting();
    out_ready = 1'b1;
    offer(3'b011, 3'b000, 3'b001, 3'b001); #1;
    tick(); idle_in(); #1;
    checks++; if (issue_mask !== 3'b011 || out_last !== 1'b1) begin errs++; $display("FAIL rw_once got=%b/%b exp=011/1", issue_mask, out_last); end
    offer(3'b011, 3'b010, 3'b011, 3'b000); #1;
    tick(); idle_in(); #1;
    checks++; if (issue_mask !== 3'b001) begin errs++; $display("FAIL brmem got=%b exp=001", issue_mask); end
    tick(); #1;
    checks++; if (issue_mask !== 3'b010 || out_last !== 1'b1) begin errs++; $display("FAIL brmem_g1 got=%b/%b exp=010/1", issue_mask, out_last); end
    offer(3'b101, 3'b010, 3'b011, 3'b010); #1;
    tick(); idle_in(); #1;
    checks++; if (issue_mask !== 3'b101 || out_last !== 1'b1) begin errs++; $display("FAIL invalid_flags got=%b/%b exp=101/1", issue_mask, out_last); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    offer(3'b111, 3'b000, 3'b000, 3'b000); #1;
    tick();
    offer(3'b011, 3'b000, 3'b011, 3'b000); #1;
    checks++; if (in_ready !== 1'b1 || out_last !== 1'b1) begin errs++; $display("FAIL b2b_ready got=%b/%b exp=1/1", in_ready, out_last); end
    tick(); idle_in(); #1;
    checks++; if (out_valid !== 1'b1 || issue_mask !== 3'b001) begin errs++; $display("FAIL b2b_next got=%b/%b exp=1/001", out_valid, issue_mask); end
    tick(); #1;
    checks++; if (issue_mask !== 3'b010 || out_last !== 1'b1) begin errs++; $display("FAIL b2b_last got=%b/%b exp=010/1", issue_mask, out_last); end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    offer(3'b111, 3'b001, 3'b000, 3'b000); #1;
    tick(); idle_in(); #1;
    tick(); #1;
    checks++; if (issue_mask !== 3'b110) begin errs++; $display("FAIL flush_setup got=%b exp=110", issue_mask); end
    flush = 1'b1; offer(3'b111, 3'b000, 3'b000, 3'b000); #1;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    tick(); flush = 1'b0; idle_in(); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL flush_clear valid/ready got=%b/%b exp=0/1", out_valid, in_ready); end
    offer(3'b001, 3'b000, 3'b000, 3'b000); #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_accept got=%b exp=1", in_ready); end
    tick(); idle_in(); #1;
    checks++; if (out_valid !== 1'b1 || issue_mask !== 3'b001) begin errs++; $display("FAIL flush_next got=%b/%b exp=1/001", out_valid, issue_mask); end
    tick();
  endtask

  task automatic test_empty_and_reset();
    out_ready = 1'b1;
    offer(3'b000, 3'b111, 3'b111, 3'b000); #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL empty_ready got=%b exp=1", in_ready); end
    tick(); idle_in(); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL empty_drop got=%b/%b exp=0/1", out_valid, in_ready); end
    out_ready = 1'b0;
    offer(3'b111, 3'b000, 3'b000, 3'b000); #1;
    tick(); idle_in(); #1;
    checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL hold_setup got=%b exp=1", out_valid); end
    reset = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
    tick(); reset = 1'b0; out_ready = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || issue_mask !== 3'b000 || out_last !== 1'b0) begin
      errs++; $display("FAIL midrst_out got=%b/%b/%b exp=0/000/0", out_valid, issue_mask, out_last);
    end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midrst_release got=%b exp=1", in_ready); end
    tick(); #1;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_nogroup got=%b exp=0", out_valid); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle_in();
    test_reset();
    test_plain();
    test_mem_split();
    test_mem_join();
    test_branch();
    test_stall();
    test_counting();
    test_back_to_back();
    test_flush();
    test_empty_and_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
